hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 fd_insn  in  32  instruction latched in F/D.
REQ-004 dx_insn  in  32  instruction latched in D/X.
REQ-005 branch_taken  in  1  X-stage redirect (taken bne/blt/beq, j, jal, jr, bex).
REQ-006 md_ready  in  1  multdiv result valid, single-cycle pulse.
REQ-007 pc_en, fd_en, dx_en  out  1 each  stage write enables.
REQ-008 fd_flush, dx_nop, xm_nop  out  1 each  load zero instruction into F/D, D/X, X/M.
REQ-009 md_start_mult, md_start_div  out  1 each  one-cycle multdiv start pulses.
REQ-010 md_result_sel  out  1  X/M takes multdiv result instead of ALU output.
REQ-011 md_busy  out  1  multdiv operation in flight.
REQ-012 md_timeout  out  1  sticky; set when multdiv exceeds the cycle limit.

Function
REQ-013 Fields: opcode [31:27], rd [26:22], rs1 [21:17], rs2 [16:12], ALU op [6:2]; register 0 never causes a hazard.
REQ-014 Decode: R=00000, addi=00101, sw=00111, lw=01000, bne=00010, blt=00110, beq=01001, jr=00100; mul = R with ALU op 00110; div = R with ALU op 00111.
REQ-015 Load-use hazard: dx is lw with dx_rd != 0, and either (a) fd reads rs1 (R, addi, lw, sw, bne, blt, beq) with fd_rs1 == dx_rd, (b) fd is R with an ALU op other than sll/sra (00100/00101) and fd_rs2 == dx_rd, or (c) fd is bne, blt, beq or jr with fd_rd == dx_rd.
REQ-016 A sw data register (fd_rd) matching a lw dx_rd does not stall; the W->M bypass covers it.
REQ-017 On a load-use hazard in IDLE: pc_en=0, fd_en=0, dx_nop=1 for exactly one cycle; the next cycle re-evaluates.
REQ-018 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE and dx is mul/div: assert md_start_mult or md_start_div for that cycle only; next state BUSY.
REQ-020 BUSY: pc_en=fd_en=dx_en=0, xm_nop=1, md_busy=1; 6-bit cycle counter increments each cycle from 0.
REQ-021 BUSY and md_ready=1: next state DONE, counter cleared.
REQ-022 BUSY and counter == 39 without md_ready: set md_timeout, next state DONE.
REQ-023 DONE (one cycle): md_result_sel=1, all enables=1, xm_nop=0; next state IDLE; the mul/div advances to X/M.
REQ-024 In the start cycle (IDLE with mul/div in dx), pc_en=fd_en=dx_en=0 and xm_nop=1.
REQ-025 branch_taken in IDLE: fd_flush=1 and dx_nop=1, enables=1; this overrides a same-cycle load-use stall.
REQ-026 branch_taken while in BUSY or DONE is ignored.
REQ-027 md_ready outside BUSY is ignored.
REQ-028 A mul/div in dx takes priority over a same-cycle load-use hazard; the load-use check resumes after DONE.
REQ-029 Back-to-back mul/div: DONE returns to IDLE, then the next dx mul/div starts a new sequence; no start pulse is issued in DONE.
REQ-030 All outputs not listed for the active condition: enables=1, other outputs=0.

Reset
REQ-031 reset low: state IDLE, counter 0, md_timeout 0.
REQ-032 reset low: pc_en=fd_en=dx_en=1; fd_flush, dx_nop, xm_nop, start pulses, md_result_sel, md_busy all 0.
REQ-033 reset asserted mid-BUSY aborts the operation; no start pulse or md_result_sel follows the release of reset.
REQ-034 Outputs derive from the current state and the instruction inputs only; they carry no reset-time residue.

Verification
REQ-035 dx=lw r5, fd=add r6,r5,r7 -> one cycle with pc_en=0, fd_en=0, dx_nop=1; then all enables return to 1.
REQ-036 dx=lw r5, fd=sw r5,0(r8) -> no stall; dx=lw r0, fd reads r0 -> no stall.
REQ-037 dx=mul: start cycle md_start_mult=1; BUSY for 17 cycles, md_ready at cycle 17 -> one DONE cycle with md_result_sel=1, then IDLE.
REQ-038 dx=div, md_ready never asserted -> md_timeout=1 after 40 BUSY cycles, DONE, IDLE; md_timeout stays 1 until reset.
REQ-039 branch_taken=1 together with a load-use hazard -> fd_flush=1, dx_nop=1, pc_en=1.
REQ-040 reset pulsed low in BUSY at cycle 5 -> md_busy=0 immediately; no md_result_sel after release.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, branch flushes and the multdiv
// start/busy/done handshake that freezes the front of the pipe.
module hazard_control (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fd_insn_i,
    input  logic [31:0] dx_insn_i,
    input  logic        branch_taken_i,
    input  logic        md_ready_i,
    output logic        pc_en_o,
    output logic        fd_en_o,
    output logic        dx_en_o,
    output logic        fd_flush_o,
    output logic        dx_nop_o,
    output logic        xm_nop_o,
    output logic        md_start_mult_o,
    output logic        md_start_div_o,
    output logic        md_result_sel_o,
    output logic        md_busy_o,
    output logic        md_timeout_o
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [5:0] CNT_LIMIT = 6'd39;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    logic [4:0] fd_op_s, fd_rd_s, fd_rs1_s, fd_rs2_s, fd_alu_s;
    logic [4:0] dx_op_s, dx_rd_s, dx_alu_s;
    logic       dx_mul_s, dx_div_s, load_use_s;
    logic       unused_s;

    assign fd_op_s  = fd_insn_i[31:27];
    assign fd_rd_s  = fd_insn_i[26:22];
    assign fd_rs1_s = fd_insn_i[21:17];
    assign fd_rs2_s = fd_insn_i[16:12];
    assign fd_alu_s = fd_insn_i[6:2];
    assign dx_op_s  = dx_insn_i[31:27];
    assign dx_rd_s  = dx_insn_i[26:22];
    assign dx_alu_s = dx_insn_i[6:2];
    assign unused_s = ^{fd_insn_i[11:7], fd_insn_i[1:0], dx_insn_i[21:7], dx_insn_i[1:0]};

    assign dx_mul_s = (dx_op_s == OP_R) && (dx_alu_s == ALU_MUL);
    assign dx_div_s = (dx_op_s == OP_R) && (dx_alu_s == ALU_DIV);

    function automatic logic reads_rs1(input logic [4:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEQ);
    endfunction

    // Branches and jr read their compare/target operand from the rd field.
    function automatic logic reads_rd(input logic [4:0] op);
        return (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEQ) || (op == OP_JR);
    endfunction

    // Load-use detection; a sw data register is bypassed W->M and never stalls.
    always_comb begin
        load_use_s = 1'b0;
        if ((dx_op_s == OP_LW) && (dx_rd_s != 5'd0)) begin
            load_use_s = (reads_rs1(fd_op_s) && (fd_rs1_s == dx_rd_s)) ||
                         ((fd_op_s == OP_R) && (fd_alu_s != ALU_SLL) &&
                          (fd_alu_s != ALU_SRA) && (fd_rs2_s == dx_rd_s)) ||
                         (reads_rd(fd_op_s) && (fd_rd_s == dx_rd_s));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next-state, busy counter and sticky timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 6'd0;
                if (dx_mul_s || dx_div_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_ready_i) begin
                    state_d = ST_DONE;
                    cnt_d   = 6'd0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d   = ST_DONE;
                    cnt_d     = 6'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Control outputs from current state and the instructions in F/D and D/X.
    always_comb begin
        pc_en_o         = 1'b1;
        fd_en_o         = 1'b1;
        dx_en_o         = 1'b1;
        fd_flush_o      = 1'b0;
        dx_nop_o        = 1'b0;
        xm_nop_o        = 1'b0;
        md_start_mult_o = 1'b0;
        md_start_div_o  = 1'b0;
        md_result_sel_o = 1'b0;
        md_busy_o       = 1'b0;
        if (!rst_ni) begin
            pc_en_o = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dx_mul_s || dx_div_s) begin
                        pc_en_o         = 1'b0;
                        fd_en_o         = 1'b0;
                        dx_en_o         = 1'b0;
                        xm_nop_o        = 1'b1;
                        md_start_mult_o = dx_mul_s;
                        md_start_div_o  = dx_div_s;
                    end else if (branch_taken_i) begin
                        fd_flush_o = 1'b1;
                        dx_nop_o   = 1'b1;
                    end else if (load_use_s) begin
                        pc_en_o  = 1'b0;
                        fd_en_o  = 1'b0;
                        dx_nop_o = 1'b1;
                    end else begin
                        pc_en_o = 1'b1;
                    end
                end
                ST_BUSY: begin
                    pc_en_o   = 1'b0;
                    fd_en_o   = 1'b0;
                    dx_en_o   = 1'b0;
                    xm_nop_o  = 1'b1;
                    md_busy_o = 1'b1;
                end
                ST_DONE: begin
                    md_result_sel_o = 1'b1;
                end
                default: begin
                    pc_en_o = 1'b1;
                end
            endcase
        end
    end

    assign md_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: a driver predicts each cycle's outputs
// from a behavioural model and queues them; a monitor compares at the falling edge.
module tb_hazard_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fd_insn = 32'd0;
    logic [31:0] dx_insn = 32'd0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop;
    logic        md_start_mult, md_start_div, md_result_sel, md_busy, md_timeout;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];
    string       cur_tag = "reset";

    // Model state: where the multdiv sequence is, in plain terms.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_tmo  = 1'b0;
    int m_busy_cycles = 0;

    hazard_control dut (
        .clk_i(clk), .rst_ni(rst_n), .fd_insn_i(fd_insn), .dx_insn_i(dx_insn),
        .branch_taken_i(branch_taken), .md_ready_i(md_ready),
        .pc_en_o(pc_en), .fd_en_o(fd_en), .dx_en_o(dx_en), .fd_flush_o(fd_flush),
        .dx_nop_o(dx_nop), .xm_nop_o(xm_nop), .md_start_mult_o(md_start_mult),
        .md_start_div_o(md_start_div), .md_result_sel_o(md_result_sel),
        .md_busy_o(md_busy), .md_timeout_o(md_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2, input int alu);
        logic [31:0] w;
        w = 32'd0;
        w[26:22] = 5'(rd); w[21:17] = 5'(rs1); w[16:12] = 5'(rs2); w[6:2] = 5'(alu);
        return w;
    endfunction

    function automatic logic [31:0] mk_i(input int op, input int rd, input int rs1);
        logic [31:0] w;
        w = 32'(($urandom & 32'h1_FFFF));
        w[31:27] = 5'(op); w[26:22] = 5'(rd); w[21:17] = 5'(rs1);
        return w;
    endfunction

    function automatic bit is_md(input logic [31:0] w);
        return (w[31:27] == 5'd0) && ((w[6:2] == 5'd6) || (w[6:2] == 5'd7));
    endfunction

    // Is register r among the registers the F/D instruction reads (sw data excluded)?
    function automatic bit fd_reads(input logic [31:0] w, input int r);
        int op, srcs[$];
        op = int'(w[31:27]);
        if (op inside {0, 5, 8, 7, 2, 6, 9}) srcs.push_back(int'(w[21:17]));
        if (op == 0 && !(int'(w[6:2]) inside {4, 5})) srcs.push_back(int'(w[16:12]));
        if (op inside {2, 6, 9, 4}) srcs.push_back(int'(w[26:22]));
        foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit load_use(input logic [31:0] fd, input logic [31:0] dx);
        if (int'(dx[31:27]) != 8 || int'(dx[26:22]) == 0) return 1'b0;
        return fd_reads(fd, int'(dx[26:22]));
    endfunction

    // Expected {pc,fd,dx,flush,dxnop,xmnop,smul,sdiv,rsel,busy,tmo} for this cycle.
    function automatic logic [10:0] predict(input logic [31:0] fd, input logic [31:0] dx,
                                            input bit br, input bit rstn);
        bit pc = 1, fe = 1, de = 1, fl = 0, dn = 0, xn = 0, sm = 0, sd = 0, rs = 0, bz = 0;
        if (!rstn) return {1'b1, 1'b1, 1'b1, 8'd0};
        if (m_busy) begin
            pc = 0; fe = 0; de = 0; xn = 1; bz = 1;
        end else if (m_done) begin
            rs = 1;
        end else if (is_md(dx)) begin
            pc = 0; fe = 0; de = 0; xn = 1;
            sm = (dx[6:2] == 5'd6); sd = (dx[6:2] == 5'd7);
        end else if (br) begin
            fl = 1; dn = 1;
        end else if (load_use(fd, dx)) begin
            pc = 0; fe = 0; dn = 1;
        end
        return {pc, fe, de, fl, dn, xn, sm, sd, rs, bz, m_tmo};
    endfunction

    task automatic model_advance(input logic [31:0] dx, input bit rdy, input bit rstn);
        if (!rstn) begin
            m_busy = 0; m_done = 0; m_tmo = 0; m_busy_cycles = 0;
        end else if (m_busy) begin
            m_busy_cycles++;
            if (rdy || m_busy_cycles == 40) begin
                if (!rdy) m_tmo = 1;
                m_busy = 0; m_done = 1;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (is_md(dx)) begin
            m_busy = 1; m_busy_cycles = 0;
        end
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx, input bit br,
                        input bit rdy, input bit rstn);
        @(posedge clk); #1;
        fd_insn = fd; dx_insn = dx; branch_taken = br; md_ready = rdy; rst_n = rstn;
        exp_q.push_back(predict(fd, dx, br, rstn));
        tag_q.push_back(cur_tag);
        model_advance(dx, rdy, rstn);
    endtask

    // Monitor: outputs are present every cycle; compare against the oldest prediction.
    initial begin
        logic [10:0] got, exp;
        string tg;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tg  = tag_q.pop_front();
                got = {pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, md_start_mult,
                       md_start_div, md_result_sel, md_busy, md_timeout};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL %s cycle=%0d {pc,fd,dx,flush,dxnop,xmnop,smul,sdiv,rsel,busy,tmo} got=%b exp=%b",
                             tg, cycle, got, exp);
                end
            end
        end
    end

    localparam logic [31:0] NOP = 32'd0;

    initial begin
        logic [31:0] lw5, add_r5, sw_r5, mulw, divw, fd_r, dx_r;
        int k;
        lw5    = mk_i(8, 5, 1);
        add_r5 = mk_r(6, 5, 7, 0);
        sw_r5  = mk_i(7, 5, 8);
        mulw   = mk_r(3, 1, 2, 6);
        divw   = mk_r(4, 1, 2, 7);

        step(NOP, NOP, 0, 0, 0);
        step(NOP, NOP, 0, 0, 0);

        cur_tag = "load_use_add";
        step(add_r5, lw5, 0, 0, 1);
        step(add_r5, NOP, 0, 0, 1);
        cur_tag = "sw_data_no_stall";
        step(sw_r5, lw5, 0, 0, 1);
        cur_tag = "r0_no_stall";
        step(mk_r(6, 0, 0, 0), mk_i(8, 0, 1), 0, 0, 1);
        cur_tag = "sll_rs2_no_stall";
        step(mk_r(6, 1, 5, 4), lw5, 0, 0, 1);
        cur_tag = "bne_rd_stall";
        step(mk_i(2, 5, 1), lw5, 0, 0, 1);
        cur_tag = "branch_over_loaduse";
        step(add_r5, lw5, 1, 0, 1);
        cur_tag = "md_ready_idle_ignored";
        step(NOP, NOP, 0, 1, 1);

        cur_tag = "mul_17";
        for (int i = 0; i < 19; i++) step(NOP, mulw, (i % 3) == 1, i == 17, 1);
        cur_tag = "mul_after";
        step(add_r5, lw5, 0, 0, 1);

        cur_tag = "back_to_back";
        for (int i = 0; i < 8; i++) step(NOP, mulw, 0, i == 2 || i == 6, 1);

        cur_tag = "div_timeout";
        for (int i = 0; i < 43; i++) step(NOP, (i < 42) ? divw : NOP, 0, 0, 1);
        cur_tag = "timeout_sticky";
        for (int i = 0; i < 3; i++) step(NOP, NOP, 0, 0, 1);

        cur_tag = "reset_mid_busy";
        for (int i = 0; i < 6; i++) step(NOP, divw, 0, 0, 1);
        step(NOP, divw, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(NOP, NOP, 0, 1, 1);

        cur_tag = "random";
        for (int n = 0; n < 1500; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: fd_r = mk_r($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 7));
                1, 2: fd_r = mk_r($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
                default: fd_r = mk_i(int'($urandom_range(2, 9)), $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
            k = $urandom_range(0, 19);
            if (k < 2)       dx_r = mk_r($urandom_range(0, 3), 1, 2, 6 + (k & 1));
            else if (k < 12) dx_r = mk_i(8, $urandom_range(0, 3), $urandom_range(0, 3));
            else             dx_r = mk_i(int'($urandom_range(2, 9)), $urandom_range(0, 3), 1);
            step(fd_r, dx_r, $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 299) != 0);
        end

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
